// File: rtl/id_stage_if.sv
// id_stage_if
// Bundles every non-clock signal of the instruction-decode stage.
//   Upstream (fetch):  if_valid, instruction[31:0], pc_in[31:0]
//   Pipeline control:  stall, flush
//   Writeback port:    wb_en, wb_dest[4:0], wb_value[31:0]
//   ID/EX outputs:     ex_valid, exe_cmd[3:0], mem_r_en, mem_w_en, wb_en_out,
//                      branch_type[1:0], dest[4:0], val1, val2, st_val,
//                      br_offset, pc_out (all 32-bit), illegal
// Modports: slave is the decode stage itself, master is whatever drives it.
interface id_stage_if;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] pc_in;
  logic        stall;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_dest;
  logic [31:0] wb_value;

  logic        ex_valid;
  logic [3:0]  exe_cmd;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        wb_en_out;
  logic [1:0]  branch_type;
  logic [4:0]  dest;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [31:0] st_val;
  logic [31:0] br_offset;
  logic [31:0] pc_out;
  logic        illegal;

  modport master (
    output if_valid, instruction, pc_in, stall, flush, wb_en, wb_dest, wb_value,
    input  ex_valid, exe_cmd, mem_r_en, mem_w_en, wb_en_out, branch_type, dest,
           val1, val2, st_val, br_offset, pc_out, illegal
  );

  modport slave (
    input  if_valid, instruction, pc_in, stall, flush, wb_en, wb_dest, wb_value,
    output ex_valid, exe_cmd, mem_r_en, mem_w_en, wb_en_out, branch_type, dest,
           val1, val2, st_val, br_offset, pc_out, illegal
  );
endinterface

// File: rtl/id_stage.sv
// id_stage
// Instruction-decode stage of the five-stage pipeline. Decodes the fetched
// instruction, reads operands from an internal 32x32 register file (written
// by writeback, with same-cycle write-through), and registers the result in
// the ID/EX boundary.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears ID/EX slot and register file)
//   bus  - id_stage_if.slave carrying fetch inputs, stall/flush, writeback
//          port and all ID/EX outputs
module id_stage (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  typedef enum logic [3:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_AND = 4'd3,
    CMD_OR  = 4'd4,
    CMD_NOR = 4'd5,
    CMD_XOR = 4'd6,
    CMD_SLA = 4'd7,
    CMD_SLL = 4'd8,
    CMD_SRA = 4'd9,
    CMD_SRL = 4'd10
  } exe_cmd_e;

  typedef struct packed {
    logic        valid;
    exe_cmd_e    cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic [1:0]  br_type;
    logic [4:0]  dest;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_val;
    logic [31:0] br_offset;
    logic [31:0] pc;
    logic        illegal;
  } idex_t;

  localparam idex_t BUBBLE = '0;

  logic [5:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_sext;

  assign op       = bus.instruction[31:26];
  assign rd       = bus.instruction[25:21];
  assign rs1      = bus.instruction[20:16];
  assign rs2      = bus.instruction[15:11];
  assign imm_sext = {{16{bus.instruction[15]}}, bus.instruction[15:0]};

  logic [31:0] regs [32];
  logic        wr_fire;

  // R0 is hard-wired to zero, so a write aimed at it never fires.
  assign wr_fire = bus.wb_en && (bus.wb_dest != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      regs[bus.wb_dest] <= bus.wb_value;
    end
  end

  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_rd;

  // Read ports: write-through bypass first, then force R0 to zero so the
  // result never depends on the array contents for address 0.
  always_comb begin
    r_rs1 = regs[rs1];
    r_rs2 = regs[rs2];
    r_rd  = regs[rd];
    if (wr_fire && bus.wb_dest == rs1) r_rs1 = bus.wb_value;
    if (wr_fire && bus.wb_dest == rs2) r_rs2 = bus.wb_value;
    if (wr_fire && bus.wb_dest == rd)  r_rd  = bus.wb_value;
    if (rs1 == 5'd0) r_rs1 = '0;
    if (rs2 == 5'd0) r_rs2 = '0;
    if (rd  == 5'd0) r_rd  = '0;
  end

  idex_t dec;

  // Decoder. An invalid fetch slot stays a full bubble; undefined opcodes
  // behave as NOP but are tagged illegal.
  always_comb begin
    dec = BUBBLE;
    if (bus.if_valid) begin
      dec.valid     = 1'b1;
      dec.dest      = rd;
      dec.br_offset = imm_sext;
      dec.pc        = bus.pc_in;
      case (op)
        6'd1, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12: begin
          dec.val1  = r_rs1;
          dec.val2  = r_rs2;
          dec.wb_en = 1'b1;
          case (op)
            6'd1:    dec.cmd = CMD_ADD;
            6'd3:    dec.cmd = CMD_SUB;
            6'd5:    dec.cmd = CMD_AND;
            6'd6:    dec.cmd = CMD_OR;
            6'd7:    dec.cmd = CMD_NOR;
            6'd8:    dec.cmd = CMD_XOR;
            6'd9:    dec.cmd = CMD_SLA;
            6'd10:   dec.cmd = CMD_SLL;
            6'd11:   dec.cmd = CMD_SRA;
            default: dec.cmd = CMD_SRL;
          endcase
        end
        6'd32, 6'd33: begin
          dec.cmd   = (op == 6'd32) ? CMD_ADD : CMD_SUB;
          dec.val1  = r_rs1;
          dec.val2  = imm_sext;
          dec.wb_en = 1'b1;
        end
        6'd36: begin
          dec.cmd      = CMD_ADD;
          dec.val1     = r_rs1;
          dec.val2     = imm_sext;
          dec.mem_r_en = 1'b1;
          dec.wb_en    = 1'b1;
        end
        6'd37: begin
          dec.cmd      = CMD_ADD;
          dec.val1     = r_rs1;
          dec.val2     = imm_sext;
          dec.st_val   = r_rd;
          dec.mem_w_en = 1'b1;
        end
        6'd40: begin
          dec.br_type = 2'b01;
          dec.val1    = r_rd;
        end
        6'd41: begin
          dec.br_type = 2'b10;
          dec.val1    = r_rd;
          dec.val2    = r_rs1;
        end
        6'd42: begin
          dec.br_type = 2'b11;
        end
        6'd0: begin
        end
        default: begin
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

  idex_t idex_q;

  // Flush wins over stall so a squashed slot never lingers during a stall.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      idex_q <= BUBBLE;
    end else if (!bus.stall) begin
      idex_q <= dec;
    end
  end

  assign bus.ex_valid    = idex_q.valid;
  assign bus.exe_cmd     = idex_q.cmd;
  assign bus.mem_r_en    = idex_q.mem_r_en;
  assign bus.mem_w_en    = idex_q.mem_w_en;
  assign bus.wb_en_out   = idex_q.wb_en;
  assign bus.branch_type = idex_q.br_type;
  assign bus.dest        = idex_q.dest;
  assign bus.val1        = idex_q.val1;
  assign bus.val2        = idex_q.val2;
  assign bus.st_val      = idex_q.st_val;
  assign bus.br_offset   = idex_q.br_offset;
  assign bus.pc_out      = idex_q.pc;
  assign bus.illegal     = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage
// Directed testbench for id_stage: reset, write/bypass, immediates, R0
// protection, stall/flush, opcode table, illegal opcodes, mid-run reset.
module tb_id_stage;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  id_stage_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {ex_valid, exe_cmd, mem_r_en, mem_w_en, wb_en_out, branch_type, illegal}
  logic [10:0] ctrl;
  assign ctrl = {bus.ex_valid, bus.exe_cmd, bus.mem_r_en, bus.mem_w_en,
                 bus.wb_en_out, bus.branch_type, bus.illegal};

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
    return {op, rd, rs1, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] d, input logic [31:0] v);
    bus.if_valid = 1'b0;
    bus.wb_en    = 1'b1;
    bus.wb_dest  = d;
    bus.wb_value = v;
    step();
    bus.wb_en    = 1'b0;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    bus.if_valid    = 1'b1;
    bus.instruction = instr;
    bus.pc_in       = pc;
    step();
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.if_valid    = 1'b1;
    bus.instruction = enc_i(6'd32, 5'd5, 5'd3, 16'h1234);
    bus.pc_in       = 32'hDEADBEEF;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.wb_en       = 1'b1;
    bus.wb_dest     = 5'd4;
    bus.wb_value    = 32'hFFFF_FFFF;
    step();
    checks++;
    if (ctrl !== 11'd0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %h expected %h", ctrl, 11'd0);
    end
    checks++;
    if ({bus.dest, bus.val1, bus.val2, bus.st_val} !== 101'd0) begin
      errors++;
      $display("[TB] FAIL reset_data: got dest=%h v1=%h v2=%h st=%h expected all 0",
               bus.dest, bus.val1, bus.val2, bus.st_val);
    end
    checks++;
    if ({bus.br_offset, bus.pc_out} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_pc: got off=%h pc=%h expected 0", bus.br_offset, bus.pc_out);
    end
    rst       = 1'b0;
    bus.wb_en = 1'b0;
    for (int r = 1; r < 32; r++) begin
      issue(enc_r(6'd1, 5'd1, 5'(r), 5'(r)), 32'h0);
      checks++;
      if ({bus.val1, bus.val2} !== 64'd0) begin
        errors++;
        $display("[TB] FAIL reset_regfile R%0d: got %h/%h expected 0", r, bus.val1, bus.val2);
      end
    end
  endtask

  task automatic test_bypass();
    bus.wb_en    = 1'b1;
    bus.wb_dest  = 5'd3;
    bus.wb_value = 32'h12345678;
    issue(enc_r(6'd1, 5'd5, 5'd3, 5'd4), 32'h10);
    bus.wb_en = 1'b0;
    checks++;
    if (ctrl !== {1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL bypass_ctrl: got %h expected %h", ctrl, {1'b1, 4'd1, 5'b00100, 1'b0});
    end
    checks++;
    if ({bus.val1, bus.val2, bus.dest} !== {32'h12345678, 32'd0, 5'd5}) begin
      errors++;
      $display("[TB] FAIL bypass_data: got v1=%h v2=%h dest=%0d expected 12345678/0/5",
               bus.val1, bus.val2, bus.dest);
    end
    issue(enc_r(6'd1, 5'd5, 5'd4, 5'd3), 32'h14);
    checks++;
    if ({bus.val1, bus.val2} !== {32'd0, 32'h12345678}) begin
      errors++;
      $display("[TB] FAIL regfile_persist: got %h/%h expected 0/12345678", bus.val1, bus.val2);
    end
  endtask

  task automatic test_immediates();
    write_reg(5'd6, 32'd10);
    issue(enc_i(6'd33, 5'd5, 5'd6, 16'hFFFE), 32'h40);
    checks++;
    if (ctrl !== {1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL subi_ctrl: got %h expected %h", ctrl, {1'b1, 4'd2, 6'b001000});
    end
    checks++;
    if ({bus.val1, bus.val2, bus.st_val} !== {32'd10, 32'hFFFFFFFE, 32'd0}) begin
      errors++;
      $display("[TB] FAIL subi_data: got %h/%h/%h expected a/fffffffe/0",
               bus.val1, bus.val2, bus.st_val);
    end
    checks++;
    if ({bus.br_offset, bus.pc_out, bus.dest} !== {32'hFFFFFFFE, 32'h40, 5'd5}) begin
      errors++;
      $display("[TB] FAIL subi_misc: got off=%h pc=%h dest=%0d expected fffffffe/40/5",
               bus.br_offset, bus.pc_out, bus.dest);
    end
    write_reg(5'd9, 32'd7);
    write_reg(5'd10, 32'd100);
    issue(enc_i(6'd37, 5'd9, 5'd10, 16'd2), 32'h44);
    checks++;
    if (ctrl !== {1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL st_ctrl: got %h expected %h", ctrl, {1'b1, 4'd1, 6'b010000});
    end
    checks++;
    if ({bus.val1, bus.val2, bus.st_val} !== {32'd100, 32'd2, 32'd7}) begin
      errors++;
      $display("[TB] FAIL st_data: got %h/%h/%h expected 64/2/7", bus.val1, bus.val2, bus.st_val);
    end
    issue(enc_i(6'd36, 5'd2, 5'd10, 16'hFFFC), 32'h48);
    checks++;
    if (ctrl !== {1'b1, 4'd1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL ld_ctrl: got %h expected %h", ctrl, {1'b1, 4'd1, 6'b101000});
    end
    checks++;
    if ({bus.val1, bus.val2, bus.st_val} !== {32'd100, 32'hFFFFFFFC, 32'd0}) begin
      errors++;
      $display("[TB] FAIL ld_data: got %h/%h/%h expected 64/fffffffc/0",
               bus.val1, bus.val2, bus.st_val);
    end
  endtask

  task automatic test_r0();
    write_reg(5'd0, 32'hDEAD);
    issue(enc_r(6'd1, 5'd1, 5'd0, 5'd0), 32'h50);
    checks++;
    if ({bus.val1, bus.val2} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL r0_write: got %h/%h expected 0/0", bus.val1, bus.val2);
    end
    bus.wb_en    = 1'b1;
    bus.wb_dest  = 5'd0;
    bus.wb_value = 32'hDEAD;
    issue(enc_r(6'd1, 5'd1, 5'd0, 5'd0), 32'h54);
    bus.wb_en = 1'b0;
    checks++;
    if ({bus.val1, bus.val2} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL r0_bypass: got %h/%h expected 0/0", bus.val1, bus.val2);
    end
  endtask

  task automatic test_stall_flush();
    write_reg(5'd13, 32'd1);
    write_reg(5'd14, 32'd2);
    issue(enc_r(6'd41, 5'd13, 5'd14, 5'd0), 32'h60);
    checks++;
    if (ctrl !== {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0} || {bus.val1, bus.val2} !== {32'd1, 32'd2}) begin
      errors++;
      $display("[TB] FAIL bne_load: got ctrl=%h v1=%h v2=%h expected %h/1/2",
               ctrl, bus.val1, bus.val2, {5'b10000, 6'b000100});
    end
    bus.stall       = 1'b1;
    bus.instruction = enc_r(6'd1, 5'd5, 5'd3, 5'd4);
    bus.pc_in       = 32'h64;
    bus.wb_en       = 1'b1;
    bus.wb_dest     = 5'd20;
    bus.wb_value    = 32'd55;
    for (int c = 0; c < 3; c++) begin
      step();
      bus.wb_en = 1'b0;
      checks++;
      if (ctrl !== {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0} ||
          {bus.val1, bus.val2, bus.pc_out} !== {32'd1, 32'd2, 32'h60}) begin
        errors++;
        $display("[TB] FAIL stall_hold c%0d: got ctrl=%h v1=%h v2=%h pc=%h expected 404/1/2/60",
                 c, ctrl, bus.val1, bus.val2, bus.pc_out);
      end
    end
    bus.flush = 1'b1;
    step();
    checks++;
    if (ctrl !== 11'd0 || {bus.val1, bus.val2, bus.pc_out} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL stall_flush: got ctrl=%h v1=%h v2=%h pc=%h expected all 0",
               ctrl, bus.val1, bus.val2, bus.pc_out);
    end
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    issue(enc_r(6'd1, 5'd1, 5'd20, 5'd0), 32'h68);
    checks++;
    if (bus.val1 !== 32'd55) begin
      errors++;
      $display("[TB] FAIL stall_wb: got %h expected 37", bus.val1);
    end
    issue(enc_r(6'd40, 5'd13, 5'd0, 5'd0), 32'h6C);
    checks++;
    if (bus.branch_type !== 2'b01 || {bus.val1, bus.val2} !== {32'd1, 32'd0}) begin
      errors++;
      $display("[TB] FAIL bez: got br=%b v1=%h v2=%h expected 01/1/0", bus.branch_type, bus.val1, bus.val2);
    end
    issue(enc_i(6'd42, 5'd13, 5'd14, 16'h0010), 32'h70);
    checks++;
    if (ctrl !== {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b0} ||
        {bus.val1, bus.val2, bus.br_offset} !== {32'd0, 32'd0, 32'h10}) begin
      errors++;
      $display("[TB] FAIL jmp: got ctrl=%h v1=%h v2=%h off=%h expected 406/0/0/10",
               ctrl, bus.val1, bus.val2, bus.br_offset);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops  [9];
    logic [3:0] cmds [9];
    ops  = '{6'd5, 6'd7, 6'd12, 6'd9, 6'd8, 6'd6, 6'd3, 6'd10, 6'd11};
    cmds = '{4'd3, 4'd5, 4'd10, 4'd7, 4'd6, 4'd4, 4'd2, 4'd8, 4'd9};
    for (int k = 0; k < 9; k++) begin
      issue(enc_r(ops[k], 5'd7, 5'd13, 5'd14), 32'h100 + 32'(k));
      checks++;
      if (ctrl !== {1'b1, cmds[k], 1'b0, 1'b0, 1'b1, 2'd0, 1'b0} ||
          {bus.val1, bus.val2, bus.dest} !== {32'd1, 32'd2, 5'd7}) begin
        errors++;
        $display("[TB] FAIL regop op%0d: got ctrl=%h v1=%h v2=%h dest=%0d expected cmd %0d 1/2/7",
                 ops[k], ctrl, bus.val1, bus.val2, bus.dest, cmds[k]);
      end
    end
  endtask

  task automatic test_illegal();
    issue(enc_r(6'd63, 5'd1, 5'd13, 5'd14), 32'h200);
    checks++;
    if (ctrl !== {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1} ||
        {bus.val1, bus.val2, bus.st_val} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL illegal_valid: got ctrl=%h v1=%h v2=%h st=%h expected 401/0/0/0",
               ctrl, bus.val1, bus.val2, bus.st_val);
    end
    bus.if_valid = 1'b0;
    step();
    checks++;
    if (ctrl !== 11'd0) begin
      errors++;
      $display("[TB] FAIL illegal_bubble: got ctrl=%h expected 0", ctrl);
    end
  endtask

  task automatic test_reset_mid();
    issue(enc_r(6'd1, 5'd2, 5'd13, 5'd14), 32'h300);
    rst = 1'b1;
    issue(enc_r(6'd1, 5'd2, 5'd13, 5'd14), 32'h304);
    checks++;
    if (ctrl !== 11'd0 || {bus.val1, bus.val2, bus.pc_out} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_out: got ctrl=%h v1=%h v2=%h pc=%h expected all 0",
               ctrl, bus.val1, bus.val2, bus.pc_out);
    end
    rst = 1'b0;
    issue(enc_r(6'd1, 5'd2, 5'd13, 5'd14), 32'h308);
    checks++;
    if ({bus.val1, bus.val2} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_regs: got %h/%h expected 0/0", bus.val1, bus.val2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bypass();
    test_immediates();
    test_r0();
    test_stall_flush();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
